// File: rtl/clock_pkg.sv
// Shared state encoding, BCD limits and the BCD step helper for the digital clock controller.
package clock_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HOUR = 3'd1,
        SET_MIN  = 3'd2,
        SET_AH   = 3'd3,
        SET_AM   = 3'd4
    } clk_state_e;

    localparam logic [7:0] BCD_MAX_MIN  = 8'h59;
    localparam logic [7:0] BCD_MAX_HOUR = 8'h23;

    // Steps a packed BCD value by one and wraps to 00 after reaching limit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] value, input logic [7:0] limit);
        logic [7:0] result;
        if (value == limit) begin
            result = 8'h00;
        end else if (value[3:0] == 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {value[7:4], value[3:0] + 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Key conditioner: two-flop synchroniser, one delay flop and a registered one-cycle rising-edge pulse.
module key_edge (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic pulse
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;
    logic pulse_q;
    logic pulse_d;

    always_comb begin
        pulse_d = sync2_q & ~dly_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/clock_ctrl.sv
// Digital clock controller: 1 Hz prescaler, counter enables, time/alarm set FSM and alarm ring timer.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned RING_SECS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       alarm_en,
    input  logic [7:0] sec_bcd,
    input  logic [7:0] min_bcd,
    input  logic [7:0] hour_bcd,
    output logic       sec_en,
    output logic       min_en,
    output logic       hour_en,
    output logic       sec_clr,
    output logic       tick_1hz,
    output logic [7:0] alarm_hour,
    output logic [7:0] alarm_min,
    output logic       alarm_ring,
    output logic [2:0] mode
);

    localparam int unsigned    CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [7:0]     RING_LOAD = 8'(RING_SECS);

    clk_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       alarm_hour_q, alarm_hour_d;
    logic [7:0]       alarm_min_q, alarm_min_d;
    logic [7:0]       ring_cnt_q, ring_cnt_d;
    logic             ring_q, ring_d;
    logic             hour_set_q, hour_set_d;
    logic             min_set_q, min_set_d;
    logic             sec_clr_q, sec_clr_d;
    logic             aen_sync1_q, aen_sync2_q;

    logic mode_p;
    logic inc_p;
    logic run;
    logic tick;
    logic set_inc;
    logic sec_wrap;
    logic min_wrap;
    logic ring_start;
    logic ring_cancel;

    key_edge u_key_mode (
        .clk   (clk),
        .reset (reset),
        .key   (key_mode),
        .pulse (mode_p)
    );

    key_edge u_key_inc (
        .clk   (clk),
        .reset (reset),
        .key   (key_inc),
        .pulse (inc_p)
    );

    assign run      = (state_q == RUN);
    assign tick     = run && (cnt_q == CNT_LAST);
    assign set_inc  = inc_p && !mode_p;
    assign sec_wrap = (sec_bcd == BCD_MAX_MIN);
    assign min_wrap = (min_bcd == BCD_MAX_MIN);

    assign ring_start  = tick && aen_sync2_q && (sec_bcd == 8'h00) &&
                         (hour_bcd == alarm_hour_q) && (min_bcd == alarm_min_q);
    assign ring_cancel = (inc_p && run) || !aen_sync2_q || mode_p;

    always_comb begin
        case (state_q)
            RUN:      state_d = mode_p ? SET_HOUR : RUN;
            SET_HOUR: state_d = mode_p ? SET_MIN  : SET_HOUR;
            SET_MIN:  state_d = mode_p ? SET_AH   : SET_MIN;
            SET_AH:   state_d = mode_p ? SET_AM   : SET_AH;
            SET_AM:   state_d = mode_p ? RUN      : SET_AM;
            default:  state_d = RUN;
        endcase
    end

    // A mode pulse out of RUN already zeroes the prescaler so SET states never see a stale count.
    always_comb begin
        cnt_d = '0;
        if (run && !mode_p) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        hour_set_d   = set_inc && (state_q == SET_HOUR);
        min_set_d    = set_inc && (state_q == SET_MIN);
        sec_clr_d    = mode_p && (state_q == SET_MIN);
        alarm_hour_d = alarm_hour_q;
        alarm_min_d  = alarm_min_q;
        if (set_inc && (state_q == SET_AH)) begin
            alarm_hour_d = bcd_inc(alarm_hour_q, BCD_MAX_HOUR);
        end
        if (set_inc && (state_q == SET_AM)) begin
            alarm_min_d = bcd_inc(alarm_min_q, BCD_MAX_MIN);
        end
    end

    // Cancel outranks a coincident start; the ring ends one cycle after the count reaches zero.
    always_comb begin
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        if (ring_cancel) begin
            ring_d     = 1'b0;
            ring_cnt_d = 8'd0;
        end else if (ring_start) begin
            ring_d     = 1'b1;
            ring_cnt_d = RING_LOAD;
        end else if (ring_q) begin
            if (ring_cnt_q == 8'd0) begin
                ring_d = 1'b0;
            end else if (tick) begin
                ring_cnt_d = ring_cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            alarm_hour_q <= 8'h00;
            alarm_min_q  <= 8'h00;
            ring_cnt_q   <= 8'd0;
            ring_q       <= 1'b0;
            hour_set_q   <= 1'b0;
            min_set_q    <= 1'b0;
            sec_clr_q    <= 1'b0;
            aen_sync1_q  <= 1'b0;
            aen_sync2_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
            ring_cnt_q   <= ring_cnt_d;
            ring_q       <= ring_d;
            hour_set_q   <= hour_set_d;
            min_set_q    <= min_set_d;
            sec_clr_q    <= sec_clr_d;
            aen_sync1_q  <= alarm_en;
            aen_sync2_q  <= aen_sync1_q;
        end
    end

    assign tick_1hz   = tick;
    assign sec_en     = tick;
    assign min_en     = (tick && sec_wrap) || min_set_q;
    assign hour_en    = (tick && sec_wrap && min_wrap) || hour_set_q;
    assign sec_clr    = sec_clr_q;
    assign alarm_hour = alarm_hour_q;
    assign alarm_min  = alarm_min_q;
    assign alarm_ring = ring_q;
    assign mode       = state_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl: a behavioural model predicts every cycle's outputs from the clock rules.
module tb_clock_ctrl;

    localparam int TICK_DIV  = 10;
    localparam int RING_SECS = 3;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       key_mode = 1'b0;
    logic       key_inc  = 1'b0;
    logic       alarm_en = 1'b0;
    logic [7:0] sec_bcd  = 8'h00;
    logic [7:0] min_bcd  = 8'h00;
    logic [7:0] hour_bcd = 8'h00;
    logic       sec_en, min_en, hour_en, sec_clr, tick_1hz, alarm_ring;
    logic [7:0] alarm_hour, alarm_min;
    logic [2:0] mode;

    logic       cur_ae = 1'b0;
    logic [7:0] cur_s  = 8'h00;
    logic [7:0] cur_m  = 8'h00;
    logic [7:0] cur_h  = 8'h00;

    // Reference model: mode index, cycles since RUN entry, alarm time as plain integers, ticks left to ring.
    int         m_mode, m_presc, m_ah, m_am, m_left;
    bit         m_ring, m_hpend, m_mpend, m_clrpend;
    logic [3:0] km_h, ki_h;
    logic [1:0] ae_h;

    logic [24:0] exp_q[$];
    int          n_compared   = 0;
    int          n_mismatched = 0;

    clock_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .RING_SECS (RING_SECS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_mode   (key_mode),
        .key_inc    (key_inc),
        .alarm_en   (alarm_en),
        .sec_bcd    (sec_bcd),
        .min_bcd    (min_bcd),
        .hour_bcd   (hour_bcd),
        .sec_en     (sec_en),
        .min_en     (min_en),
        .hour_en    (hour_en),
        .sec_clr    (sec_clr),
        .tick_1hz   (tick_1hz),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .alarm_ring (alarm_ring),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic model_reset();
        m_mode    = 0;
        m_presc   = 0;
        m_ah      = 0;
        m_am      = 0;
        m_left    = 0;
        m_ring    = 1'b0;
        m_hpend   = 1'b0;
        m_mpend   = 1'b0;
        m_clrpend = 1'b0;
        km_h      = 4'b0000;
        ki_h      = 4'b0000;
        ae_h      = 2'b00;
    endtask

    // Drives one cycle of inputs, queues the predicted outputs for that cycle, then advances the model.
    task automatic applyStimulus(input logic r, input logic km, input logic ki);
        logic mp, ip, aes, tick, start, cancel, e_sec, e_min, e_hour;
        reset    = r;
        key_mode = km;
        key_inc  = ki;
        alarm_en = cur_ae;
        sec_bcd  = cur_s;
        min_bcd  = cur_m;
        hour_bcd = cur_h;
        if (!r) begin
            model_reset();
            exp_q.push_back(25'd0);
        end else begin
            mp     = km_h[2] & ~km_h[3];
            ip     = ki_h[2] & ~ki_h[3];
            aes    = ae_h[1];
            tick   = (m_mode == 0) && (m_presc == TICK_DIV - 1);
            e_sec  = tick;
            e_min  = (tick && cur_s == 8'h59) || m_mpend;
            e_hour = (tick && cur_s == 8'h59 && cur_m == 8'h59) || m_hpend;
            exp_q.push_back({e_sec, e_min, e_hour, m_clrpend, tick, m_ring,
                             3'(m_mode), to_bcd(m_ah), to_bcd(m_am)});
            cancel = (ip && m_mode == 0) || !aes || mp;
            start  = tick && aes && cur_s == 8'h00 && cur_h == to_bcd(m_ah) && cur_m == to_bcd(m_am);
            if (cancel) begin
                m_ring = 1'b0;
                m_left = 0;
            end else if (start) begin
                m_ring = 1'b1;
                m_left = RING_SECS;
            end else if (m_ring) begin
                if (m_left == 0) m_ring = 1'b0;
                else if (tick) m_left = m_left - 1;
            end
            m_hpend   = (m_mode == 1) && ip && !mp;
            m_mpend   = (m_mode == 2) && ip && !mp;
            m_clrpend = (m_mode == 2) && mp;
            if (ip && !mp && m_mode == 3) m_ah = (m_ah + 1) % 24;
            if (ip && !mp && m_mode == 4) m_am = (m_am + 1) % 60;
            m_presc = (m_mode == 0 && !mp) ? (m_presc + 1) % TICK_DIV : 0;
            if (mp) m_mode = (m_mode + 1) % 5;
            km_h = {km_h[2:0], km};
            ki_h = {ki_h[2:0], ki};
            ae_h = {ae_h[0], cur_ae};
        end
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input logic [24:0] e);
        logic [24:0] a;
        a = {sec_en, min_en, hour_en, sec_clr, tick_1hz, alarm_ring, mode, alarm_hour, alarm_min};
        n_compared++;
        if (a !== e) begin
            n_mismatched++;
            $display("[TB] FAIL outputs t=%0t got en=%b clr=%b tick=%b ring=%b mode=%0d alarm=%h:%h required en=%b clr=%b tick=%b ring=%b mode=%0d alarm=%h:%h",
                     $time, a[24:22], a[21], a[20], a[19], a[18:16], a[15:8], a[7:0],
                     e[24:22], e[21], e[20], e[19], e[18:16], e[15:8], e[7:0]);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    task automatic run_cycles(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    task automatic press(input logic is_mode, input int hold, input int count);
        repeat (count) begin
            repeat (hold) applyStimulus(1'b1, is_mode, !is_mode);
            run_cycles(3);
        end
    endtask

    initial begin
        int km_left;
        int ki_left;
        km_left = 0;
        ki_left = 0;
        model_reset();
        #1 reset = 1'b0;
        @(posedge clk);
        #2;

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        run_cycles(25);

        cur_h = 8'h23; cur_m = 8'h59; cur_s = 8'h59;
        run_cycles(22);
        cur_h = 8'h00; cur_m = 8'h00; cur_s = 8'h00;

        press(1'b1, 2, 1);
        press(1'b0, 2, 3);
        press(1'b1, 2, 2);
        press(1'b0, 2, 31);
        press(1'b1, 2, 1);
        press(1'b0, 2, 90);
        press(1'b1, 2, 1);

        cur_ae = 1'b1;
        run_cycles(5);
        cur_h = 8'h07; cur_m = 8'h30; cur_s = 8'h00;
        run_cycles(TICK_DIV);
        cur_s = 8'h01;
        run_cycles(50);

        cur_s = 8'h00;
        run_cycles(TICK_DIV);
        cur_s = 8'h01;
        run_cycles(12);
        press(1'b0, 2, 1);
        run_cycles(20);

        cur_s = 8'h00;
        run_cycles(TICK_DIV);
        cur_s = 8'h01;
        run_cycles(5);
        cur_ae = 1'b0;
        run_cycles(10);
        cur_ae = 1'b1;
        run_cycles(5);

        cur_s = 8'h00;
        run_cycles(TICK_DIV);
        cur_s = 8'h01;
        run_cycles(3);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        run_cycles(25);

        press(1'b1, 2, 1);
        press(1'b0, 4, 1);
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b1);
        run_cycles(6);
        press(1'b1, 2, 3);

        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic km, ki;
            if (km_left == 0 && $urandom_range(0, 99) < 3) km_left = int'($urandom_range(1, 6));
            if (ki_left == 0 && $urandom_range(0, 99) < 6) ki_left = int'($urandom_range(1, 6));
            km = (km_left > 0);
            ki = (ki_left > 0);
            if (km_left > 0) km_left--;
            if (ki_left > 0) ki_left--;
            if ($urandom_range(0, 99) < 10) begin
                case ($urandom_range(0, 3))
                    0: begin
                        cur_h = to_bcd(int'($urandom_range(0, 23)));
                        cur_m = to_bcd(int'($urandom_range(0, 59)));
                        cur_s = to_bcd(int'($urandom_range(0, 59)));
                    end
                    1: begin
                        cur_h = 8'h23; cur_m = 8'h59; cur_s = 8'h59;
                    end
                    2: begin
                        cur_h = to_bcd(m_ah); cur_m = to_bcd(m_am); cur_s = 8'h00;
                    end
                    default: begin
                        cur_m = 8'h59; cur_s = 8'h59;
                    end
                endcase
            end
            if ($urandom_range(0, 99) == 0) cur_ae = ~cur_ae;
            applyStimulus(1'b1, km, ki);
        end

        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
